// File: rtl/sdram_wb_bridge_pkg.sv
// Shared types and constants for the SDRAM Wishbone bridge.
// Holds the FSM state encoding, bus widths and parameter defaults.
package sdram_wb_bridge_pkg;

    localparam int SDRAM_AW      = 22;
    localparam int SDRAM_DW      = 16;
    localparam int ACK_DELAY_DEF = 2;
    localparam int TIMEOUT_DEF   = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DELAY,
        S_ACK,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/sdram_wb_cnt.sv
// Loadable down-counter shared by the ack delay and request timeout.
// last_o flags the final counted cycle (value 1, or 0 if loaded empty).
module sdram_wb_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q <= W'(1));

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave to SDRAM controller request/ack bridge.
// One transaction at a time; bounded wait on the controller ack.
module sdram_wb_bridge
    import sdram_wb_bridge_pkg::*;
#(
    parameter int ACK_DELAY = ACK_DELAY_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                clk_p,
    input  logic                rst_n,
    input  logic                wb_stb,
    input  logic                wb_we,
    input  logic [1:0]          wb_sel,
    input  logic [20:0]         wb_adr,
    input  logic [15:0]         wb_dat_i,
    output logic [15:0]         wb_dat_o,
    output logic                wb_ack,
    output logic                sd_wr_req,
    output logic                sd_rd_req,
    input  logic                sd_wr_ack,
    input  logic                sd_rd_ack,
    output logic [SDRAM_AW-1:0] sd_addr,
    output logic [SDRAM_DW-1:0] sd_wdata,
    input  logic [SDRAM_DW-1:0] sd_rdata,
    input  logic                sd_init_done,
    output logic [1:0]          dqm,
    output logic                timeout_err
);

    localparam int MAXV = (TIMEOUT > ACK_DELAY) ? TIMEOUT : ACK_DELAY;
    localparam int CW   = $clog2(MAXV + 1);

    logic [1:0]          rst_sync_q;
    logic                rst_sync_n;
    state_e              state_q, state_d;
    logic                pend_q, pend_d;
    logic                we_q;
    logic [20:0]         adr_q;
    logic [SDRAM_DW-1:0] wdata_q;
    logic [1:0]          dqm_q;
    logic [SDRAM_DW-1:0] rdata_q;
    logic                err_q;
    logic                latch, cap, tmo;
    logic                cnt_load, cnt_en, cnt_last;
    logic [CW-1:0]       cnt_val;
    logic                ack_m;
    logic                req_on;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    sdram_wb_cnt #(
        .W (CW)
    ) u_cnt (
        .clk_i  (clk_p),
        .rst_ni (rst_sync_n),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .en_i   (cnt_en),
        .last_o (cnt_last)
    );

    // Only the ack matching the latched direction counts.
    assign ack_m = we_q ? sd_wr_ack : sd_rd_ack;

    // Next state, counter control and datapath strobes.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        latch    = 1'b0;
        cap      = 1'b0;
        tmo      = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wb_stb && sd_init_done) begin
                    state_d  = S_REQ;
                    latch    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(TIMEOUT);
                end
            end
            S_REQ: begin
                if (ack_m) begin
                    cap = ~we_q & wb_stb;
                    if (wb_stb) begin
                        state_d  = S_DELAY;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(ACK_DELAY);
                    end else begin
                        state_d = S_DRAIN;
                        pend_d  = 1'b0;
                    end
                end else if (cnt_last) begin
                    tmo     = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_en = 1'b1;
                    if (!wb_stb) begin
                        state_d = S_DRAIN;
                        pend_d  = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (!wb_stb) begin
                    state_d = S_DRAIN;
                    pend_d  = 1'b0;
                end else if (cnt_last) begin
                    state_d = S_ACK;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_ACK: begin
                if (!wb_stb) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!pend_q || ack_m) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else if (cnt_last) begin
                    tmo     = 1'b1;
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // FSM state and abandoned-request flag.
    always_ff @(posedge clk_p or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Command latch, read data capture and sticky timeout flag.
    always_ff @(posedge clk_p or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            dqm_q   <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (latch) begin
                we_q    <= wb_we;
                adr_q   <= wb_adr;
                wdata_q <= wb_dat_i;
                dqm_q   <= wb_we ? ~wb_sel : 2'b00;
            end
            if (tmo) begin
                rdata_q <= 16'hFFFF;
                err_q   <= 1'b1;
            end else if (cap) begin
                rdata_q <= sd_rdata;
            end
        end
    end

    // A drained request stays up until the controller finishes it.
    assign req_on = (state_q == S_REQ) ||
                    ((state_q == S_DRAIN) && pend_q);

    assign sd_wr_req   = req_on & we_q;
    assign sd_rd_req   = req_on & ~we_q;
    assign wb_ack      = (state_q == S_ACK) & wb_stb;
    assign sd_addr     = {1'b0, adr_q};
    assign sd_wdata    = wdata_q;
    assign dqm         = dqm_q;
    assign wb_dat_o    = rdata_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge with a scripted controller.
// Drives and samples on the falling clock edge.
module tb_sdram_wb_bridge;

    localparam int ACK_DELAY = 2;
    localparam int TIMEOUT   = 8;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  dqm;
        logic [15:0] rdata;
    } txn_t;

    logic        clk_p = 1'b0;
    logic        rst_n;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic [20:0] wb_adr;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack;
    logic        sd_wr_req;
    logic        sd_rd_req;
    logic        sd_wr_ack;
    logic        sd_rd_ack;
    logic [21:0] sd_addr;
    logic [15:0] sd_wdata;
    logic [15:0] sd_rdata;
    logic        sd_init_done;
    logic [1:0]  dqm;
    logic        timeout_err;

    int          checks = 0;
    int          errors = 0;
    txn_t        sb[$];
    logic [15:0] last_rd;

    always #5 clk_p = ~clk_p;

    sdram_wb_bridge #(
        .ACK_DELAY (ACK_DELAY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .wb_stb       (wb_stb),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_adr       (wb_adr),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack       (wb_ack),
        .sd_wr_req    (sd_wr_req),
        .sd_rd_req    (sd_rd_req),
        .sd_wr_ack    (sd_wr_ack),
        .sd_rd_ack    (sd_rd_ack),
        .sd_addr      (sd_addr),
        .sd_wdata     (sd_wdata),
        .sd_rdata     (sd_rdata),
        .sd_init_done (sd_init_done),
        .dqm          (dqm),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"},
              {29'd0, wb_ack, sd_wr_req, sd_rd_req}, 32'd0);
        check({tag, "_addr"}, {10'd0, sd_addr}, 32'd0);
        check({tag, "_wd"}, {16'd0, sd_wdata}, 32'd0);
        check({tag, "_dqm"}, {30'd0, dqm}, 32'd0);
        check({tag, "_rd"}, {16'd0, wb_dat_o}, 32'd0);
        check({tag, "_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    task automatic run_txn(input logic        we,
                           input logic [1:0]  sel,
                           input logic [20:0] adr,
                           input logic [15:0] wd,
                           input logic [15:0] rd,
                           input int          lat);
        txn_t t;
        int   n;
        int   d;
        t.we    = we;
        t.addr  = {1'b0, adr};
        t.wdata = wd;
        t.dqm   = we ? ~sel : 2'b00;
        t.rdata = we ? last_rd : rd;
        sb.push_back(t);
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_sel   = sel;
        wb_adr   = adr;
        wb_dat_i = wd;
        n = 0;
        @(negedge clk_p);
        wb_sel   = ~sel;
        wb_adr   = ~adr;
        wb_dat_i = ~wd;
        for (int c = 0; c < 40; c++) begin
            sd_wr_ack = 1'b0;
            sd_rd_ack = 1'b0;
            if (sd_wr_req || sd_rd_req) begin
                n++;
                if (n == 1) begin
                    check("dir", {30'd0, sd_wr_req, sd_rd_req},
                          {30'd0, sb[0].we, ~sb[0].we});
                    check("addr", {10'd0, sd_addr},
                          {10'd0, sb[0].addr});
                    check("dqm", {30'd0, dqm}, {30'd0, sb[0].dqm});
                    if (sb[0].we) begin
                        check("wdata", {16'd0, sd_wdata},
                              {16'd0, sb[0].wdata});
                    end
                end
            end
            if (n == lat) break;
            if (n == 1) begin
                sd_wr_ack = ~we;
                sd_rd_ack = we;
            end
            @(negedge clk_p);
        end
        check("req_len", n, lat);
        sd_wr_ack = we;
        sd_rd_ack = ~we;
        sd_rdata  = rd;
        @(negedge clk_p);
        sd_wr_ack = 1'b0;
        sd_rd_ack = 1'b0;
        sd_rdata  = 16'hDEAD;
        check("req_drop", {30'd0, sd_wr_req, sd_rd_req}, 32'd0);
        d = 1;
        for (int c = 0; c < 20; c++) begin
            if (wb_ack) break;
            d++;
            @(negedge clk_p);
        end
        check("ack_lat", d, ACK_DELAY + 1);
        t = sb.pop_front();
        check("rdata", {16'd0, wb_dat_o}, {16'd0, t.rdata});
        last_rd = t.rdata;
        wb_stb = 1'b0;
        #1;
        check("ack_gate", {31'd0, wb_ack}, 32'd0);
        @(negedge clk_p);
        check("ack_end", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic run_drain();
        int n;
        int bad;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_sel = 2'b11;
        wb_adr = 21'h00777;
        n   = 0;
        bad = 0;
        @(negedge clk_p);
        wb_stb = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sd_rd_req) n++;
            if (wb_ack) bad++;
            if (n == 4) break;
            @(negedge clk_p);
        end
        check("drn_len", n, 4);
        sd_rd_ack = 1'b1;
        sd_rdata  = 16'h5555;
        @(negedge clk_p);
        sd_rd_ack = 1'b0;
        check("drn_drop", {31'd0, sd_rd_req}, 32'd0);
        if (wb_ack) bad++;
        @(negedge clk_p);
        if (wb_ack) bad++;
        check("drn_noack", bad, 0);
    endtask

    task automatic run_timeout();
        int n;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_sel = 2'b00;
        wb_adr = 21'h0ABCD;
        n = 0;
        @(negedge clk_p);
        for (int c = 0; c < 40; c++) begin
            if (sd_rd_req) n++;
            else if (n > 0) break;
            @(negedge clk_p);
        end
        check("to_len", n, TIMEOUT);
        check("to_ack", {31'd0, wb_ack}, 32'd1);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_dat", {16'd0, wb_dat_o}, 32'h0000FFFF);
        last_rd = 16'hFFFF;
        wb_stb = 1'b0;
        @(negedge clk_p);
        check("to_end", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic run_nogo();
        int bad;
        bad = 0;
        sd_init_done = 1'b0;
        wb_stb = 1'b1;
        wb_we  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_p);
            if (sd_wr_req || sd_rd_req || wb_ack) bad++;
        end
        check("nogo", bad, 0);
        wb_stb = 1'b0;
        sd_init_done = 1'b1;
        @(negedge clk_p);
    endtask

    task automatic run_rst_delay();
        int bad;
        bad = 0;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_sel = 2'b11;
        wb_adr = 21'h00042;
        @(negedge clk_p);
        check("rd_req", {31'd0, sd_rd_req}, 32'd1);
        sd_rd_ack = 1'b1;
        sd_rdata  = 16'h1111;
        @(negedge clk_p);
        sd_rd_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        wb_stb = 1'b0;
        @(negedge clk_p);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_p);
            if (wb_ack) bad++;
        end
        check("rst_noack", bad, 0);
        last_rd = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        wb_stb       = 1'b0;
        wb_we        = 1'b0;
        wb_sel       = 2'b00;
        wb_adr       = '0;
        wb_dat_i     = '0;
        sd_wr_ack    = 1'b0;
        sd_rd_ack    = 1'b0;
        sd_rdata     = '0;
        sd_init_done = 1'b1;
        last_rd      = 16'h0000;
        repeat (3) @(negedge clk_p);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_p);
        sd_rd_ack = 1'b1;
        sd_wr_ack = 1'b1;
        @(negedge clk_p);
        sd_rd_ack = 1'b0;
        sd_wr_ack = 1'b0;
        check("idle_ack",
              {29'd0, wb_ack, sd_wr_req, sd_rd_req}, 32'd0);
        @(negedge clk_p);
        run_txn(1'b0, 2'b01, 21'h00100, 16'h0000, 16'hA5C3, 5);
        run_txn(1'b1, 2'b10, 21'h1ABCD, 16'h1234, 16'h0000, 3);
        run_txn(1'b1, 2'b01, 21'h00003, 16'hBEEF, 16'h0000, 1);
        run_txn(1'b0, 2'b00, 21'h1FFFFF, 16'h0000, 16'h0F0F, 2);
        run_drain();
        run_txn(1'b0, 2'b11, 21'h00200, 16'h0000, 16'h3C3C, 2);
        run_timeout();
        run_nogo();
        run_rst_delay();
        run_txn(1'b0, 2'b11, 21'h00055, 16'h0000, 16'h7E81, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
